// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared stage encodings, instruction type codes and memory command payload
// for the multi-cycle CPU stage sequencer.
package cpu_stage_sequencer_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned STAGE_WIDTH      = 3;
  localparam int unsigned INSTR_TYPE_WIDTH = 5;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE            = 3'd0,
    STAGE_FETCH           = 3'd1,
    STAGE_DECODE          = 3'd2,
    STAGE_EXECUTE         = 3'd3,
    STAGE_MEMORY          = 3'd4,
    STAGE_REGISTER_UPDATE = 3'd5,
    STAGE_HALTED          = 3'd6
  } stage_e;

  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_NO_OP          = 5'd0;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_LOAD_IMMEDIATE = 5'd1;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_LOAD           = 5'd2;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_STORE          = 5'd3;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_ALU_OP         = 5'd4;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_JUMP           = 5'd5;
  localparam logic [INSTR_TYPE_WIDTH-1:0] INSTR_HALT           = 5'd6;

  typedef struct packed {
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
  } mem_cmd_t;

  function automatic logic is_defined_type(input logic [INSTR_TYPE_WIDTH-1:0] t);
    case (t)
      INSTR_NO_OP, INSTR_LOAD_IMMEDIATE, INSTR_LOAD, INSTR_STORE,
      INSTR_ALU_OP, INSTR_JUMP, INSTR_HALT: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_stage_sequencer_mem_wait_timer.sv
// Counts consecutive cycles a memory request waits for ready; flags expiry on
// the MEM_TIMEOUT-th unanswered cycle.
module cpu_stage_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired_c
);

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  assign expired_c = tick && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick && !expired_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle stage FSM: owns PC and instruction register, sequences
// FETCH/DECODE/EXECUTE/MEMORY/REGISTER_UPDATE and handshakes with memory.
module cpu_stage_sequencer
  import cpu_stage_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mem_ready,
  input  logic [XLEN-1:0]             mem_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [XLEN-1:0]             mem_addr,
  input  logic [XLEN-1:0]             data_addr,
  input  logic [XLEN-1:0]             jump_cond,
  input  logic [XLEN-1:0]             jump_target,
  output logic [STAGE_WIDTH-1:0]      stage,
  output logic [INSTR_TYPE_WIDTH-1:0] current_instruction_type,
  output logic [XLEN-1:0]             instr,
  output logic [XLEN-1:0]             load_data,
  output logic [XLEN-1:0]             pc,
  output logic                        halted,
  output logic                        fault,
  output logic [XLEN-1:0]             retired
);

  stage_e                      state_q, state_d;
  logic [XLEN-1:0]             pc_q, pc_d;
  logic [XLEN-1:0]             instr_q, instr_d;
  logic [XLEN-1:0]             load_q, load_d;
  logic [XLEN-1:0]             retired_q, retired_d;
  logic                        fault_q, fault_d;
  logic                        halted_q;
  logic [INSTR_TYPE_WIDTH-1:0] itype;
  mem_cmd_t                    cmd;
  logic                        waiting;
  logic                        timer_tick;
  logic                        timer_clear;
  logic                        expired_c;

  assign itype = instr_q[INSTR_TYPE_WIDTH-1:0];

  // Only FETCH and MEMORY own a request; ready elsewhere is ignored.
  assign waiting     = (state_q == STAGE_FETCH) || (state_q == STAGE_MEMORY);
  assign timer_tick  = waiting && !mem_ready;
  assign timer_clear = !waiting || mem_ready;

  cpu_stage_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .expired_c(expired_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= STAGE_IDLE;
      pc_q      <= PC_RESET;
      instr_q   <= '0;
      load_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      load_q    <= load_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      halted_q  <= (state_d == STAGE_HALTED);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    load_d    = load_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    cmd       = '0;
    case (state_q)
      STAGE_IDLE: begin
        if (start) state_d = STAGE_FETCH;
      end
      STAGE_FETCH: begin
        cmd.req  = 1'b1;
        cmd.addr = pc_q;
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = STAGE_DECODE;
        end else if (expired_c) begin
          fault_d = 1'b1;
          state_d = STAGE_HALTED;
        end
      end
      STAGE_DECODE: begin
        if (itype == INSTR_HALT) begin
          state_d = STAGE_HALTED;
        end else if (!is_defined_type(itype)) begin
          fault_d = 1'b1;
          state_d = STAGE_HALTED;
        end else begin
          state_d = STAGE_EXECUTE;
        end
      end
      STAGE_EXECUTE: begin
        if (itype == INSTR_LOAD || itype == INSTR_STORE) state_d = STAGE_MEMORY;
        else                                            state_d = STAGE_REGISTER_UPDATE;
      end
      STAGE_MEMORY: begin
        cmd.req  = 1'b1;
        cmd.we   = (itype == INSTR_STORE);
        cmd.addr = data_addr;
        if (mem_ready) begin
          if (itype == INSTR_LOAD) load_d = mem_rdata;
          state_d = STAGE_REGISTER_UPDATE;
        end else if (expired_c) begin
          fault_d = 1'b1;
          state_d = STAGE_HALTED;
        end
      end
      STAGE_REGISTER_UPDATE: begin
        if (itype == INSTR_JUMP && jump_cond != '0) pc_d = jump_target;
        else                                       pc_d = pc_q + 32'd1;
        retired_d = retired_q + 32'd1;
        state_d   = STAGE_FETCH;
      end
      STAGE_HALTED: begin
        state_d = STAGE_HALTED;
      end
      default: begin
        state_d = STAGE_IDLE;
      end
    endcase
  end

  assign mem_req                  = cmd.req;
  assign mem_we                   = cmd.we;
  assign mem_addr                 = cmd.addr;
  assign stage                    = state_q;
  assign current_instruction_type = itype;
  assign instr                    = instr_q;
  assign load_data                = load_q;
  assign pc                       = pc_q;
  assign halted                   = halted_q;
  assign fault                    = fault_q;
  assign retired                  = retired_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer: hand-computed stage, PC, memory
// handshake, timeout and reset expectations.
module tb_cpu_stage_sequencer;
  import cpu_stage_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] data_addr;
  logic [31:0] jump_cond;
  logic [31:0] jump_target;
  logic [2:0]  stage;
  logic [4:0]  current_instruction_type;
  logic [31:0] instr;
  logic [31:0] load_data;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  cpu_stage_sequencer #(
    .PC_RESET   (32'h0000_0000),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .mem_ready               (mem_ready),
    .mem_rdata               (mem_rdata),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .data_addr               (data_addr),
    .jump_cond               (jump_cond),
    .jump_target             (jump_target),
    .stage                   (stage),
    .current_instruction_type(current_instruction_type),
    .instr                   (instr),
    .load_data               (load_data),
    .pc                      (pc),
    .halted                  (halted),
    .fault                   (fault),
    .retired                 (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH: stall 'waits' cycles, then return 'word'; ends in DECODE.
  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) step();
    mem_ready = 1'b1;
    mem_rdata = word;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    data_addr   = '0;
    jump_cond   = '0;
    jump_target = '0;
    step();
    step();

    // reset state
    chk("rst_stage",   32'(stage), 32'd0);
    chk("rst_pc",      pc, 32'h0);
    chk("rst_instr",   instr, 32'h0);
    chk("rst_load",    load_data, 32'h0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_req",     32'(mem_req), 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_fault",   32'(fault), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_hold", 32'(stage), 32'd0);

    // 1: ALU_OP with same-cycle ready
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_fetch",      32'(stage), 32'd1);
    chk("t1_fetch_req",  32'(mem_req), 32'd1);
    chk("t1_fetch_addr", mem_addr, 32'h0);
    chk("t1_fetch_we",   32'(mem_we), 32'd0);
    fetch(32'hABC0_0000 | 32'(INSTR_ALU_OP), 0);
    chk("t1_decode",  32'(stage), 32'd2);
    chk("t1_instr",   instr, 32'hABC0_0004);
    chk("t1_type",    32'(current_instruction_type), 32'd4);
    chk("t1_dec_req", 32'(mem_req), 32'd0);
    step();
    chk("t1_exec", 32'(stage), 32'd3);
    step();
    chk("t1_regupd", 32'(stage), 32'd5);
    step();
    chk("t1_refetch", 32'(stage), 32'd1);
    chk("t1_pc",      pc, 32'd1);
    chk("t1_retired", retired, 32'd1);
    chk("t1_addr",    mem_addr, 32'd1);

    // 2: LOAD with 3 wait cycles in MEMORY
    data_addr = 32'h40;
    fetch(32'(INSTR_LOAD), 0);
    step();
    step();
    chk("t2_mem",      32'(stage), 32'd4);
    chk("t2_mem_addr", mem_addr, 32'h40);
    chk("t2_mem_we",   32'(mem_we), 32'd0);
    chk("t2_mem_req",  32'(mem_req), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("t2_wait", 32'(stage), 32'd4);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk("t2_regupd", 32'(stage), 32'd5);
    chk("t2_load",   load_data, 32'hDEAD_BEEF);
    step();
    chk("t2_pc",      pc, 32'd2);
    chk("t2_retired", retired, 32'd2);

    // 3: JUMP not taken, then taken
    jump_cond   = 32'd0;
    jump_target = 32'h20;
    fetch(32'(INSTR_JUMP), 1);
    step();
    chk("t3a_exec", 32'(stage), 32'd3);
    step();
    step();
    chk("t3a_pc", pc, 32'd3);
    jump_cond = 32'd5;
    fetch(32'(INSTR_JUMP), 0);
    step();
    step();
    step();
    chk("t3b_pc",      pc, 32'h20);
    chk("t3b_retired", retired, 32'd4);
    chk("t3b_addr",    mem_addr, 32'h20);

    // 4: STORE with memory never ready -> timeout
    data_addr = 32'h80;
    fetch(32'(INSTR_STORE), 0);
    step();
    step();
    chk("t4_mem",      32'(stage), 32'd4);
    chk("t4_mem_we",   32'(mem_we), 32'd1);
    chk("t4_mem_addr", mem_addr, 32'h80);
    for (int i = 0; i < 15; i++) step();
    chk("t4_wait15", 32'(stage), 32'd4);
    step();
    chk("t4_halted_stage", 32'(stage), 32'd6);
    chk("t4_fault",        32'(fault), 32'd1);
    chk("t4_halted",       32'(halted), 32'd1);
    chk("t4_req",          32'(mem_req), 32'd0);
    chk("t4_retired",      retired, 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_absorb", 32'(stage), 32'd6);

    // 5a: HALT instruction
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(32'(INSTR_HALT), 0);
    step();
    chk("t5a_stage", 32'(stage), 32'd6);
    chk("t5a_fault", 32'(fault), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5a_absorb", 32'(stage), 32'd6);

    // 5b: undefined type 31
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(32'h0000_001F, 0);
    step();
    chk("t5b_stage",   32'(stage), 32'd6);
    chk("t5b_fault",   32'(fault), 32'd1);
    chk("t5b_retired", retired, 32'd0);

    // 6: async reset during a FETCH wait
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(32'(INSTR_NO_OP), 0);
    step();
    step();
    step();
    chk("t6_pc1", pc, 32'd1);
    step();
    step();
    chk("t6_wait_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req",   32'(mem_req), 32'd0);
    chk("t6_stage", 32'(stage), 32'd0);
    chk("t6_pc",    pc, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk("t6_late_ready", 32'(stage), 32'd0);
    chk("t6_instr",      instr, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_refetch",      32'(stage), 32'd1);
    chk("t6_refetch_addr", mem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Multi-cycle stage FSM for the single-issue CPU.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and REGISTER_UPDATE.
- Drives `stage` and `current_instruction_type` into register_file_control, owns the PC and the instruction register, and handshakes with main memory for fetches, loads and stores.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, maximum cycles any memory request waits for mem_ready before a fault.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching at pc.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_rdata  input  32  read data, valid when mem_ready.
- mem_req  output  1  memory request active.
- mem_we  output  1  request is a write (STORE only).
- mem_addr  output  32  pc during fetch; data_addr during MEMORY.
- data_addr  input  32  load/store address from the register file read port.
- jump_cond  input  32  jump condition register value.
- jump_target  input  32  jump address register value.
- stage  output  `STAGE_WIDTH  current stage encoding.
- current_instruction_type  output  5  instr_reg[4:0]; valid from DECODE onward.
- instr  output  32  instruction register.
- load_data  output  32  data latched by LOAD, fed to load_mem_data.
- pc  output  32  program counter.
- halted  output  1  FSM is in HALTED.
- fault  output  1  halt caused by illegal opcode or memory timeout.
- retired  output  32  count of completed instructions.

Behaviour:
- Reset (async, rst=0) sets:
  - stage=IDLE, pc=PC_RESET, instr=0, load_data=0, retired=0.
  - mem_req=0, mem_we=0, halted=0, fault=0, timeout counter=0.
- Stage encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, REGISTER_UPDATE=5, HALTED=6.
- IDLE: start=1 -> FETCH next cycle. Otherwise hold.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - mem_ready=1: instr<=mem_rdata, go to DECODE.
  - Otherwise increment the timeout counter.
- DECODE: exactly one cycle; type is taken from instr[4:0].
  - HALT -> HALTED, fault=0.
  - Undefined type -> HALTED, fault=1.
  - All other types -> EXECUTE.
- EXECUTE: exactly one cycle.
  - LOAD or STORE -> MEMORY.
  - Otherwise -> REGISTER_UPDATE.
- MEMORY: mem_req=1, mem_addr=data_addr, mem_we=1 only for STORE.
  - On mem_ready, LOAD latches load_data<=mem_rdata.
  - Then go to REGISTER_UPDATE.
- REGISTER_UPDATE: exactly one cycle; register_file_control gates write_enable itself. At exit:
  - pc<=jump_target if type==JUMP and jump_cond!=0, else pc<=pc+1 (32-bit wrap).
  - retired<=retired+1 (wraps).
  - Next stage FETCH.
- Timeout counter:
  - Clears on entry to FETCH/MEMORY and whenever mem_ready=1.
  - Reaching MEM_TIMEOUT with no ready -> HALTED, fault=1, mem_req drops that cycle.
  - The faulting instruction does not retire.
- mem_req is deasserted in every stage other than FETCH and MEMORY.
- mem_ready outside a request is ignored.
- HALTED: absorbing state; only reset exits. start is ignored.
- start while not in IDLE: ignored.
- Reset asserted mid-request: mem_req drops immediately (async). A late mem_ready after reset is ignored.
- All outputs are registered except mem_addr/mem_we/mem_req, which are decoded from stage.

Decomposition:
- Shared arch_defines include: `STAGE_WIDTH ([2:0]), `STAGE_* encodings, `INSTR_* type codes (LOAD_IMMEDIATE, LOAD, STORE, ALU_OP, JUMP, HALT, NO_OP), INSTR_TYPE_WIDTH=5.
- One sub-module: mem_wait_timer (counter, clear, expire flag, MEM_TIMEOUT parameter), reused for the FETCH and MEMORY waits.

Test Plan:
1. Reset, start, memory ready same cycle, mem[0]=ALU_OP -> stages 1,2,3,5,1; pc=1, retired=1; the ALU instruction takes 4 cycles.
2. mem[1]=LOAD, data_addr=0x40, mem_ready after 3 wait cycles returning 0xDEADBEEF -> load_data=0xDEADBEEF; mem_addr=0x40 in MEMORY; mem_we=0.
3. JUMP with jump_cond=0 -> pc=pc+1; JUMP with jump_cond=5, jump_target=0x20 -> pc=0x20.
4. STORE with mem_ready held low (MEM_TIMEOUT=16) -> after 16 MEMORY cycles stage=6, fault=1, mem_req=0, retired unchanged.
5. instr[4:0]=HALT -> HALTED after DECODE, fault=0, start ignored. instr[4:0]=31 (undefined) -> HALTED, fault=1.
6. rst asserted low during a FETCH wait -> mem_req=0 and stage=IDLE immediately; pc=PC_RESET; a subsequent start refetches address 0.
